muldiv_sequencer: RTL
=====================

# muldiv_sequencer

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair beside the MIPS datapath ALU. It accepts one `mult`/`multu`/`div`/`divu` request from the controller, iterates a shift-add or restoring-divide datapath for `n` cycles, applies sign correction, then writes HI/LO. While busy it raises a stall towards the CPU for any conflicting HI/LO access.

## Interface
- `n`, 32: operand, HI and LO width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: request pulse, sampled on the rising edge when idle.
- `op` input 2: 00 `mult` (signed), 01 `multu`, 10 `div` (signed), 11 `divu`.
- `a` input n: rs operand (multiplicand / dividend), captured with `start`.
- `b` input n: rt operand (multiplier / divisor), captured with `start`.
- `hi_we` input 1: `mthi` write strobe; writes `wdata` to HI.
- `lo_we` input 1: `mtlo` write strobe; writes `wdata` to LO.
- `wdata` input n: data for `mthi`/`mtlo`.
- `rd_req` input 1: CPU is executing `mfhi`/`mflo` this cycle.
- `hi` output n: HI register. Reset value 0.
- `lo` output n: LO register. Reset value 0.
- `busy` output 1: operation in flight. Reset value 0.
- `done` output 1: one-cycle pulse when HI/LO are updated. Reset value 0.
- `divzero` output 1: sticky flag; last divide had `b == 0`. Cleared by the next accepted `start`. Reset value 0.
- `stall` output 1: combinational; `busy & (start | rd_req | hi_we | lo_we)`.

## Operation
- States:
  - IDLE: `busy=0`. On `start`, latch `op`, `a`, `b` and go to RUN with counter = n-1.
  - RUN: one iteration per cycle. Leave for FIX when the counter reaches 0.
  - FIX: write HI/LO, pulse `done`, return to IDLE.
- Operand preparation at `start`:
  - Signed ops: latch |a| and |b|.
  - Record `neg_res = a[n-1]^b[n-1]` and `neg_rem = a[n-1]`, both for signed ops only.
- Multiply:
  - 2n-bit accumulator; LSB-first shift-add with the unsigned multiplier.
  - FIX: if `neg_res`, two's-complement negate the 2n-bit product.
  - HI = product[2n-1:n], LO = product[n-1:0].
- Divide:
  - Restoring algorithm, one quotient bit per cycle.
  - FIX: negate the quotient if `neg_res`; negate the remainder if `neg_rem`.
  - LO = quotient, HI = remainder.
- Divide by zero (`b==0`, op 10/11):
  - Full latency is still spent.
  - FIX writes LO = all ones, HI = `a` (original, uncorrected); `divzero` is set.
- Overflow: `div` of 0x80000000 by 0xFFFFFFFF gives LO = 0x80000000, HI = 0 (natural wrap, no flag).
- `mthi`/`mtlo`:
  - In IDLE, write on the edge; both strobes together write both registers.
  - While busy, the write is ignored and `stall=1`; the CPU holds the instruction until `busy=0`.
- `start` while busy: ignored, `stall=1`, no operand capture.
- `start` together with `hi_we`/`lo_we` in IDLE: `start` wins; the writes are dropped.
- `rd_req` in IDLE: no effect. `hi`/`lo` are read directly.

## Timing
- Edge 0 samples `start`:
  - `busy=1` from after edge 0 until after edge n+1.
  - RUN covers edges 1..n.
  - Edge n+1 (FIX) writes HI/LO.
- Results appear on `hi`/`lo` after edge n+1; `done=1` and `busy=0` for the cycle that follows.
  - Total latency is n+1 edges (33 for n=32).
- A new `start` is accepted on the edge immediately after `done` (cycle n+2); back-to-back throughput is one op per n+2 cycles.
- HI/LO hold their previous values throughout RUN; intermediates live in separate registers.
- Reset asserted at any time, including mid-RUN:
  - Immediately forces IDLE.
  - Clears `hi`, `lo`, `busy`, `done` and `divzero`.
  - Discards the in-flight operation; no partial result is written.
- `stall` has no registered delay. It depends only on the current-cycle inputs and `busy`.

## Test plan
- `mult`, a=7, b=0xFFFFFFFD (-3): after 33 edges, HI=0xFFFFFFFF, LO=0xFFFFFFEB, `done` pulses once, `busy` drops.
- `multu`, a=b=0xFFFFFFFF: HI=0xFFFFFFFE, LO=0x00000001.
- `div`, a=0xFFFFFFF9 (-7), b=2: LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then `divu`, a=100, b=7: LO=14, HI=2.
- `divu`, a=0x1234, b=0: `divzero=1`, LO=0xFFFFFFFF, HI=0x1234. The next `mult` start clears `divzero`.
- Hazards:
  - Pulse `start`, `rd_req` and `hi_we` (wdata=0xDEAD) at cycle 5 of a busy op: `stall=1` each cycle, no capture, and HI ends at the multiply result rather than 0xDEAD.
  - `mthi` 0xDEAD in IDLE: HI=0xDEAD next cycle.
- Reset at cycle 10 of `mult` 3×5: HI=LO=0, `busy=0`, no `done`. A fresh `mult` 3×5 then gives LO=15, HI=0.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO pair beside the ALU.
// Shift-add multiply / restoring divide on magnitudes, sign fixed up in a final cycle.
module muldiv_sequencer #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [n-1:0] wdata,
  input  logic         rd_req,
  output logic [n-1:0] hi,
  output logic [n-1:0] lo,
  output logic         busy,
  output logic         done,
  output logic         divzero,
  output logic         stall
);

  localparam int cnt_w = $clog2(n);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_nxt;
  logic [cnt_w-1:0]   cnt;
  logic               is_div, neg_res, neg_rem, b_zero;
  logic [n-1:0]       m, acc_hi, acc_lo, a_orig;

  // operand preparation
  logic               is_signed;
  logic [n-1:0]       a_abs, b_abs;

  // iteration datapath
  logic [n:0]         add_sum;
  logic [n:0]         rem_sh;
  logic               fits;
  logic [n-1:0]       rem_sub;

  // final correction
  logic [2*n-1:0]     prod, prod_fix;
  logic [n-1:0]       res_hi, res_lo;

  assign is_signed = ~op[0];
  assign a_abs     = (is_signed && a[n-1]) ? -a : a;
  assign b_abs     = (is_signed && b[n-1]) ? -b : b;

  // Multiply: acc_hi is the running upper half, acc_lo holds the multiplier
  // shifting out LSB-first while product bits shift in from the top.
  assign add_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? m : {n{1'b0}})};

  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and
  // quotient bits in. The remainder stays below m, so the n-bit subtract is exact.
  assign rem_sh    = {acc_hi, acc_lo[n-1]};
  assign fits      = rem_sh >= {1'b0, m};
  assign rem_sub   = rem_sh[n-1:0] - m;

  assign prod      = {acc_hi, acc_lo};
  assign prod_fix  = neg_res ? -prod : prod;

  always_comb begin
    res_hi = prod_fix[2*n-1:n];
    res_lo = prod_fix[n-1:0];
    if (is_div) begin
      if (b_zero) begin
        res_hi = a_orig;
        res_lo = {n{1'b1}};
      end else begin
        res_hi = neg_rem ? -acc_hi : acc_hi;
        res_lo = neg_res ? -acc_lo : acc_lo;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == '0) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    stall = busy & (start | rd_req | hi_we | lo_we);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      b_zero  <= 1'b0;
      m       <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      a_orig  <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      divzero <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt     <= cnt_w'(n - 1);
            is_div  <= op[1];
            neg_res <= is_signed & (a[n-1] ^ b[n-1]);
            neg_rem <= is_signed & a[n-1];
            b_zero  <= (b == '0);
            a_orig  <= a;
            acc_hi  <= '0;
            m       <= op[1] ? b_abs : a_abs;
            acc_lo  <= op[1] ? a_abs : b_abs;
            divzero <= 1'b0;
          end else begin
            // start takes priority; mthi/mtlo only land on a non-start idle edge
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (is_div) begin
            acc_hi <= fits ? rem_sub : rem_sh[n-1:0];
            acc_lo <= {acc_lo[n-2:0], fits};
          end else begin
            {acc_hi, acc_lo} <= {add_sum, acc_lo[n-1:1]};
          end
        end
        FIX: begin
          hi   <= res_hi;
          lo   <= res_lo;
          done <= 1'b1;
          if (is_div && b_zero) divzero <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
